// File: rtl/tt_sel_driver.sv
// Host-side tile-selection initiator: deselect, N increment pulses, enable, user reset hold, active.
// Optional TT_SEL_SKIP_EN: re-requesting the current selection from ACTIVE only re-pulses the user reset.
module tt_sel_driver #(
  parameter int ADDR_W  = 10,
  parameter int PULSE_W = 2,
  parameter int RST_CYC = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              release_i,
  output logic              busy,
  output logic              done,
  output logic              ctrl_sel_rst_n,
  output logic              ctrl_sel_inc,
  output logic              ctrl_ena,
  output logic              um_rst_n
);

  localparam int PH_MAX = (PULSE_W > RST_CYC) ? PULSE_W : RST_CYC;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0] PH_PULSE = PH_W'(PULSE_W - 1);
  localparam logic [PH_W-1:0] PH_RST   = PH_W'(RST_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DESEL, S_INC_HI, S_INC_LO, S_URST, S_ACTIVE
  } state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready_q, busy_q, done_q, was_act_q;
  logic              sel_rst_n_q, inc_q, ena_q, um_rst_n_q;
  logic              accept, ph_last;

`ifdef TT_SEL_SKIP_EN
  logic [ADDR_W-1:0] tgt_q, tgt_d, cur_addr_q, cur_addr_d;
  logic              cur_vld_q, cur_vld_d;
`endif

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    accept  = req_valid && ((state_q == S_IDLE) || (state_q == S_ACTIVE));
    ph_last = (phase_q == '0);
`ifdef TT_SEL_SKIP_EN
    tgt_d      = tgt_q;
    cur_addr_d = cur_addr_q;
    cur_vld_d  = cur_vld_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d   = req_addr;
          state_d = S_DESEL;
          phase_d = PH_PULSE;
`ifdef TT_SEL_SKIP_EN
          tgt_d   = req_addr;
`endif
        end
      end
      S_DESEL: begin
        if (!ph_last) begin
          phase_d = phase_q - PH_W'(1);
        end else if (cnt_q != '0) begin
          state_d = S_INC_HI;
          phase_d = PH_PULSE;
        end else begin
          state_d = S_URST;
          phase_d = PH_RST;
        end
      end
      S_INC_HI: begin
        if (!ph_last) begin
          phase_d = phase_q - PH_W'(1);
        end else begin
          state_d = S_INC_LO;
          phase_d = PH_PULSE;
        end
      end
      S_INC_LO: begin
        if (!ph_last) begin
          phase_d = phase_q - PH_W'(1);
        end else begin
          cnt_d = cnt_q - ADDR_W'(1);
          // Compare against 1 so the exit decision uses the post-decrement count.
          if (cnt_q != ADDR_W'(1)) begin
            state_d = S_INC_HI;
            phase_d = PH_PULSE;
          end else begin
            state_d = S_URST;
            phase_d = PH_RST;
          end
        end
      end
      S_URST: begin
        if (!ph_last) begin
          phase_d = phase_q - PH_W'(1);
        end else begin
          state_d = S_ACTIVE;
`ifdef TT_SEL_SKIP_EN
          cur_addr_d = tgt_q;
          cur_vld_d  = 1'b1;
`endif
        end
      end
      S_ACTIVE: begin
        if (accept) begin
          cnt_d   = req_addr;
          state_d = S_DESEL;
          phase_d = PH_PULSE;
`ifdef TT_SEL_SKIP_EN
          tgt_d = req_addr;
          if (cur_vld_q && (req_addr == cur_addr_q)) begin
            state_d = S_URST;
            phase_d = PH_RST;
          end else begin
            cur_vld_d = 1'b0;
          end
`endif
        end else if (release_i) begin
          state_d = S_IDLE;
`ifdef TT_SEL_SKIP_EN
          cur_vld_d = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      cnt_q   <= '0;
`ifdef TT_SEL_SKIP_EN
      tgt_q      <= '0;
      cur_addr_q <= '0;
      cur_vld_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
`ifdef TT_SEL_SKIP_EN
      tgt_q      <= tgt_d;
      cur_addr_q <= cur_addr_d;
      cur_vld_q  <= cur_vld_d;
`endif
    end
  end

  // Handshake flags track the state register; pad drives and done lag it by one register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      was_act_q   <= 1'b0;
      sel_rst_n_q <= 1'b0;
      inc_q       <= 1'b0;
      ena_q       <= 1'b0;
      um_rst_n_q  <= 1'b0;
    end else begin
      ready_q     <= (state_d == S_IDLE) || (state_d == S_ACTIVE);
      busy_q      <= (state_d != S_IDLE) && (state_d != S_ACTIVE);
      was_act_q   <= (state_q == S_ACTIVE);
      done_q      <= (state_q == S_ACTIVE) && !was_act_q;
      sel_rst_n_q <= (state_q != S_IDLE) && (state_q != S_DESEL);
      inc_q       <= (state_q == S_INC_HI);
      ena_q       <= (state_q == S_URST) || (state_q == S_ACTIVE);
      um_rst_n_q  <= (state_q == S_ACTIVE);
    end
  end

  assign req_ready      = ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign ctrl_sel_rst_n = sel_rst_n_q;
  assign ctrl_sel_inc   = inc_q;
  assign ctrl_ena       = ena_q;
  assign um_rst_n       = um_rst_n_q;

endmodule

// File: tb/tb_tt_sel_driver.sv
// Bench for tt_sel_driver: timeline model of the selection sequence plus literal latency checks.
module tb_tt_sel_driver;
  localparam int ADDR_W  = 10;
  localparam int PULSE_W = 2;
  localparam int RST_CYC = 8;

  logic clk = 1'b0;
  logic rst_n, req_valid, release_i;
  logic [ADDR_W-1:0] req_addr;
  logic req_ready_w, busy_w, done_w, sel_rst_n_w, inc_w, ena_w, um_rst_n_w;

  tt_sel_driver #(.ADDR_W(ADDR_W), .PULSE_W(PULSE_W), .RST_CYC(RST_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready_w), .release_i(release_i), .busy(busy_w), .done(done_w),
    .ctrl_sel_rst_n(sel_rst_n_w), .ctrl_sel_inc(inc_w), .ctrl_ena(ena_w),
    .um_rst_n(um_rst_n_w)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  // Model: a selection is a timeline of m_len state-cycles starting at acceptance, then ACTIVE.
  bit m_seq, m_skip, m_cur_vld;
  int m_j, m_len, m_addr, m_cur;
  logic [6:0] exp_v;  // {ready,busy,done,sel_rst_n,inc,ena,um_rst_n}
  int ncyc = 0, t_acc = 0, t_ena = -1, t_done = -1, inc_rises = 0;
  logic prev_ena = 1'b0, prev_inc = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // {done,sel_rst_n,inc,ena,um_rst_n} during the current model state-cycle
  function automatic logic [4:0] view();
    int j;
    if (!m_seq) return 5'b00000;
    if (m_j >= m_len) return {(m_j == m_len), 4'b1011};
    if (m_skip) return 5'b01010;
    j = m_j;
    if (j < PULSE_W) return 5'b00000;
    j -= PULSE_W;
    if (j < 2 * PULSE_W * m_addr) return {2'b01, ((j % (2 * PULSE_W)) < PULSE_W), 2'b00};
    return 5'b01010;
  endfunction

  task automatic model_reset();
    m_seq = 0; m_skip = 0; m_cur_vld = 0; m_j = 0; m_len = 0;
    exp_v = 7'b1000000;
  endtask

  task automatic model_step();
    logic [4:0] v;
    bit active, rdy, skip;
    v = view();
    active = m_seq && (m_j >= m_len);
    rdy = !m_seq || active;
    if (req_valid && rdy) begin
      skip = 0;
`ifdef TT_SEL_SKIP_EN
      skip = active && m_cur_vld && (m_cur == int'(req_addr));
      if (!skip) m_cur_vld = 0;
`endif
      m_seq = 1; m_j = 0; m_addr = int'(req_addr); m_skip = skip;
      m_len = skip ? RST_CYC : PULSE_W + 2 * PULSE_W * m_addr + RST_CYC;
      t_acc = ncyc; t_ena = -1; t_done = -1; inc_rises = 0;
    end else if (active && release_i) begin
      m_seq = 0; m_cur_vld = 0;
    end else if (m_seq && m_j <= m_len) begin
      m_j++;
      if (m_j == m_len) begin m_cur_vld = 1; m_cur = m_addr; end
    end
    rdy = !m_seq || (m_j >= m_len);
    exp_v = {rdy, !rdy, v};
  endtask

  task automatic tick();
    @(posedge clk);
    ncyc++;
    if (rst_n) model_step();
    @(negedge clk);
    chk($sformatf("outputs@%0d", ncyc),
        int'({req_ready_w, busy_w, done_w, sel_rst_n_w, inc_w, ena_w, um_rst_n_w}), int'(exp_v));
    if (inc_w && !sel_rst_n_w) chk("inc_while_desel", 1, 0);
    if (ena_w && !prev_ena && t_ena < 0) t_ena = ncyc - t_acc;
    if (done_w && t_done < 0) t_done = ncyc - t_acc;
    if (inc_w && !prev_inc) inc_rises++;
    prev_ena = ena_w; prev_inc = inc_w;
  endtask

  task automatic request(input int addr);
    req_valid = 1'b1; req_addr = ADDR_W'(addr);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int n = 0;
    while (t_done < 0 && n < bound) begin tick(); n++; end
    if (t_done < 0) chk({name, "_timeout"}, 0, 1);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; release_i = 1'b0; req_addr = '0;
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Full selection of design 3 from IDLE
    request(3);
    wait_done("sel3", 100);
    chk("sel3_ena_cycle", t_ena, 15);
    chk("sel3_done_cycle", t_done, 23);
    chk("sel3_inc_edges", inc_rises, 3);

    // Design 0 from ACTIVE: no increment pulses
    request(0);
    wait_done("sel0", 100);
    chk("sel0_ena_cycle", t_ena, 3);
    chk("sel0_done_cycle", t_done, 11);
    chk("sel0_inc_edges", inc_rises, 0);

    // Requests held during busy are neither accepted nor queued
    request(2);
    for (int i = 0; i < 100 && !req_ready_w; i++) begin
      req_valid = 1'b1; req_addr = ADDR_W'(7 + 2 * (i % 2));
      release_i = (i == 5);
      tick();
    end
    req_valid = 1'b0; release_i = 1'b0;
    wait_done("sel2", 100);
    chk("sel2_inc_edges", inc_rises, 2);

    // Simultaneous release and request: reselection wins
    release_i = 1'b1;
    request(1);
    release_i = 1'b0;
    wait_done("sel1", 100);
    chk("sel1_ena_cycle", t_ena, 7);
    chk("sel1_done_cycle", t_done, 15);
    chk("sel1_inc_edges", inc_rises, 1);

    // Plain release returns to IDLE
    release_i = 1'b1; tick(); release_i = 1'b0;
    repeat (3) tick();
    chk("release_ena", int'(ena_w), 0);

    // Asynchronous reset in the middle of an increment-high phase
    request(4);
    for (int i = 0; i < 50 && !inc_w; i++) tick();
    chk("pre_reset_inc", int'(inc_w), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outs",
        int'({req_ready_w, busy_w, done_w, sel_rst_n_w, inc_w, ena_w, um_rst_n_w}), 7'b1000000);
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_ready", int'(req_ready_w), 1);

    // Select 5, then re-request 5 from ACTIVE
    request(5);
    wait_done("sel5", 100);
    chk("sel5_done_cycle", t_done, 31);
    request(5);
    wait_done("resel5", 100);
`ifdef TT_SEL_SKIP_EN
    chk("resel5_done_cycle", t_done, 9);
    chk("resel5_inc_edges", inc_rises, 0);
`else
    chk("resel5_done_cycle", t_done, 31);
    chk("resel5_inc_edges", inc_rises, 5);
`endif

    // Maximum address: 1023 pulses, no wrap
    request(1023);
    wait_done("sel_max", 5000);
    chk("selmax_inc_edges", inc_rises, 1023);
    chk("selmax_done_cycle", t_done, 2 + 4 * 1023 + 8 + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
